wb_reg_bank: RTL

Parametrised Wishbone classic slave register bank; successor to the fixed 8-register write-only control slave feeding the video_in pipeline. Provides NREGS 32-bit registers with byte-enable writes and registered readback. Per-register mode masks make each register read/write, self-clearing (command pulse) or read-only (status from the datapath). Adds error response on bad addresses and per-register write strobes.

---
 rtl/wb_reg_bank.sv | 103 ++++++++++
 1 files changed

// File: rtl/wb_reg_bank.sv
// Wishbone classic slave register bank: NREGS x 32-bit registers with byte-enable
// writes, registered readback, self-clearing command registers and read-only status words.
module wb_reg_bank #(
  parameter logic [31:0]      BASE_ADDR     = 32'hb000_0000,
  parameter int unsigned      NREGS         = 8,
  parameter logic [NREGS-1:0] SELF_CLR_MASK = NREGS'(8'hAA),
  parameter logic [NREGS-1:0] RO_MASK       = '0
) (
  input  logic                  p_clk,
  input  logic                  p_resetn,
  input  logic [31:0]           p_wb_DAT_I,
  output logic [31:0]           p_wb_DAT_O,
  input  logic [31:0]           p_wb_ADR_I,
  output logic                  p_wb_ACK_O,
  input  logic                  p_wb_CYC_I,
  output logic                  p_wb_ERR_O,
  input  logic                  p_wb_LOCK_I,
  output logic                  p_wb_RTY_O,
  input  logic [3:0]            p_wb_SEL_I,
  input  logic                  p_wb_STB_I,
  input  logic                  p_wb_WE_I,
  output logic [32*NREGS-1:0]   p_regs_o,
  output logic [NREGS-1:0]      p_reg_wr_o,
  input  logic [32*NREGS-1:0]   p_status_i
);

  localparam int unsigned IW   = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [31:0] SPAN = 32'(4 * NREGS);

  logic [31:0]      regs_q [NREGS];
  logic [31:0]      regs_d [NREGS];
  logic             ack_q, err_q;
  logic [31:0]      dat_q;
  logic [NREGS-1:0] wr_q;

  logic [31:0]      offset_c;
  logic             hit_c, accept_c, ro_c, write_c;
  logic [IW-1:0]    idx_c;
  logic [31:0]      merged_c, rdata_c;
  logic             unused_c;

  assign unused_c = p_wb_LOCK_I;

  // Address decode relative to the bank base
  assign offset_c = p_wb_ADR_I - BASE_ADDR;
  assign hit_c    = (p_wb_ADR_I >= BASE_ADDR) && (offset_c < SPAN) && (p_wb_ADR_I[1:0] == 2'b00);
  assign idx_c    = offset_c[IW+1:2];
  assign accept_c = p_wb_CYC_I && p_wb_STB_I && !ack_q && !err_q;
  assign ro_c     = RO_MASK[idx_c];
  assign write_c  = accept_c && hit_c && p_wb_WE_I && !ro_c;

  // Byte-lane merge of write data into the addressed register
  always_comb begin
    merged_c = regs_q[idx_c];
    for (int k = 0; k < 4; k++) begin
      if (p_wb_SEL_I[k]) merged_c[8*k +: 8] = p_wb_DAT_I[8*k +: 8];
    end
  end

  assign rdata_c = ro_c ? p_status_i[{idx_c, 5'd0} +: 32] : regs_q[idx_c];

  // Self-clearing registers drop to zero one edge after being loaded
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = (SELF_CLR_MASK[i] || RO_MASK[i]) ? 32'h0 : regs_q[i];
      if (write_c && (idx_c == IW'(i))) regs_d[i] = merged_c;
    end
  end

  always_ff @(posedge p_clk or negedge p_resetn) begin
    if (!p_resetn) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= 32'h0;
    end else begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  // Registered bus termination, read data and write strobes
  always_ff @(posedge p_clk or negedge p_resetn) begin
    if (!p_resetn) begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      dat_q <= 32'h0;
      wr_q  <= '0;
    end else begin
      ack_q <= accept_c && hit_c;
      err_q <= accept_c && !hit_c;
      dat_q <= (accept_c && hit_c && !p_wb_WE_I) ? rdata_c : 32'h0;
      wr_q  <= write_c ? (NREGS'(1) << idx_c) : '0;
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_regs_out
    assign p_regs_o[32*g +: 32] = regs_q[g];
  end

  assign p_wb_ACK_O = ack_q;
  assign p_wb_ERR_O = err_q;
  assign p_wb_DAT_O = dat_q;
  assign p_wb_RTY_O = 1'b0;
  assign p_reg_wr_o = wr_q;

endmodule
